bin_to_display_fmt: RTL and testbench

// Sequential binary-to-BCD formatter feeding the 7-segment display decoder stage.

---
 rtl/bin_to_display_fmt.sv | 127 ++++++++++++
 tb/tb_bin_to_display_fmt.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_display_fmt.sv
// Sequential binary-to-BCD formatter (double-dabble, one bit per clock)
// feeding the 7-segment decoder; shows "Erro" on overflow or error flag.
module bin_to_display_fmt #(
    parameter int DIGITS   = 8,
    parameter int WIDTH    = 27,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       value,
    input  logic                   error_in,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS-1:0][3:0] displays
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'(10) ** DIGITS - 64'd1;

    localparam logic [3:0] C_E     = 4'b1111;
    localparam logic [3:0] C_R     = 4'b1110;
    localparam logic [3:0] C_O     = 4'b1101;
    localparam logic [3:0] C_BLANK = 4'b1010;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       shift_q;
    logic [BW-1:0]          bcd_q;
    logic [CW-1:0]          cnt_q;

    logic [BW-1:0]          adj;
    logic [BW+WIDTH-1:0]    work_next;
    logic [BW-1:0]          bcd_next;
    logic [WIDTH-1:0]       shift_next;
    logic [DIGITS-1:0][3:0] fmt;
    logic [DIGITS-1:0][3:0] err_pat;
    logic                   err_path;
    logic                   last;
    logic                   seen;

    assign err_path = error_in || (64'(value) > MAX_VAL);
    assign last     = (cnt_q == CW'(1));
    assign busy     = (state == CONVERT);

    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ?
                            bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
        end
        work_next  = {adj, shift_q} << 1;
        bcd_next   = work_next[BW+WIDTH-1:WIDTH];
        shift_next = work_next[WIDTH-1:0];
    end

    // Digits above the most significant nonzero one blank; digit 0 never does.
    always_comb begin
        fmt  = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_next[4*i +: 4] != 4'd0) seen = 1'b1;
            if (LZ_BLANK && !seen && i != 0) fmt[i] = C_BLANK;
            else                             fmt[i] = bcd_next[4*i +: 4];
        end
    end

    always_comb begin
        err_pat = '0;
        for (int i = 0; i < DIGITS; i++) err_pat[i] = C_BLANK;
        err_pat[3] = C_E;
        err_pat[2] = C_R;
        err_pat[1] = C_R;
        err_pat[0] = C_O;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start && !err_path) state_next = CONVERT;
            CONVERT: if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            displays <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && err_path) begin
                    displays <= err_pat;
                    done     <= 1'b1;
                end else if (start) begin
                    shift_q <= value;
                    bcd_q   <= '0;
                    cnt_q   <= CW'(WIDTH);
                end
            end else begin
                shift_q <= shift_next;
                bcd_q   <= bcd_next;
                cnt_q   <= cnt_q - CW'(1);
                if (last) begin
                    displays <= fmt;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_display_fmt.sv
// Directed vector bench for bin_to_display_fmt, with a blanking
// instance alongside the default one and multi-cycle corner sequences.
module tb_bin_to_display_fmt;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [26:0]     value;
    logic            error_in;
    logic            busy, done;
    logic [7:0][3:0] displays;
    logic            busy_lz, done_lz;
    logic [7:0][3:0] disp_lz;

    int total  = 0;
    int passed = 0;

    bin_to_display_fmt dut (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .error_in(error_in), .busy(busy), .done(done),
        .displays(displays)
    );

    bin_to_display_fmt #(.LZ_BLANK(1'b1)) dut_lz (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .error_in(error_in), .busy(busy_lz), .done(done_lz),
        .displays(disp_lz)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [26:0] value;
        logic        err;
        logic [31:0] exp;
        logic [31:0] exp_lz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run(input logic [26:0] v, input logic e,
                       output int lat, output int bcnt);
        value    = v;
        error_in = e;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        error_in = 1'b0;
        lat      = 0;
        bcnt     = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clock);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat, bcnt, dn, bad;
        vecs[0] = '{27'd12345678, 1'b0, 32'h12345678, 32'h12345678, 27};
        vecs[1] = '{27'd0,        1'b0, 32'h00000000, 32'hAAAAAAA0, 27};
        vecs[2] = '{27'd99999999, 1'b0, 32'h99999999, 32'h99999999, 27};
        vecs[3] = '{27'd100000000,1'b0, 32'hAAAAFEED, 32'hAAAAFEED, 0};
        vecs[4] = '{27'd5,        1'b1, 32'hAAAAFEED, 32'hAAAAFEED, 0};
        vecs[5] = '{27'd42,       1'b0, 32'h00000042, 32'hAAAAAA42, 27};
        vecs[6] = '{27'h7FFFFFF,  1'b0, 32'hAAAAFEED, 32'hAAAAFEED, 0};
        vecs[7] = '{27'd1,        1'b0, 32'h00000001, 32'hAAAAAAA1, 27};
        vecs[8] = '{27'd10000000, 1'b0, 32'h10000000, 32'h10000000, 27};
        vecs[9] = '{27'd90506070, 1'b0, 32'h90506070, 32'h90506070, 27};

        reset    = 1'b1;
        start    = 1'b0;
        value    = '0;
        error_in = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_disp", displays, 32'h0);
        chk("rst_disp_lz", disp_lz, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].value, vecs[i].err, lat, bcnt);
            chk($sformatf("v%0d_disp", i), displays, vecs[i].exp);
            chk($sformatf("v%0d_disp_lz", i), disp_lz, vecs[i].exp_lz);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'(vecs[i].lat));
            @(negedge clock);
            chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
        end

        // Start while busy must be ignored, not queued.
        value = 27'd42;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        value = 27'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        value = '0;
        dn = 0;
        repeat (70) begin
            if (done) dn++;
            @(negedge clock);
        end
        chk("ign_dones", 32'(dn), 32'd1);
        chk("ign_disp", displays, 32'h00000042);
        chk("ign_busy", 32'(busy), 32'd0);

        // Reset in the middle of a conversion.
        value = 27'd12345678;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_disp", displays, 32'h0);
        chk("mid_rst_disp_lz", disp_lz, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        dn = 0;
        repeat (35) begin
            if (done) dn++;
            @(negedge clock);
        end
        chk("mid_rst_nodone", 32'(dn), 32'd0);
        run(27'd12345678, 1'b0, lat, bcnt);
        chk("post_rst_disp", displays, 32'h12345678);
        chk("post_rst_lat", 32'(lat), 32'd27);

        // Back to back: second start in the done cycle.
        run(27'd11111111, 1'b0, lat, bcnt);
        chk("b2b_first", displays, 32'h11111111);
        value = 27'd22222222;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        bad = 0;
        while (!done && lat < 100) begin
            if (displays !== 32'h11111111) bad++;
            @(negedge clock);
            lat++;
        end
        chk("b2b_hold", 32'(bad), 32'd0);
        chk("b2b_lat", 32'(lat), 32'd27);
        chk("b2b_second", displays, 32'h22222222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
